// File: rtl/nibble_serial_add16_if.sv
// Operand/result bundle for the nibble-serial 16-bit adder/subtractor.
// The requester drives the operands and start; the adder returns status and the registered result.
interface nibble_serial_add16_if;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        ovf;
  logic        zero;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, sum, c_out, ovf, zero
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/nibble_serial_add16.sv
// 16-bit add/subtract computed one nibble per cycle through a single 4-bit adder.
// Subtraction is a + ~b + 1, so the carry out means "no borrow".
module nibble_serial_add16 (
  input  logic                         clk,
  input  logic                         rst,
  nibble_serial_add16_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] op_a_r;
  logic [15:0] op_b_r;
  logic [15:0] partial_r;
  logic        carry_r;
  logic [1:0]  idx_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] sum_r;
  logic        c_out_r;
  logic        ovf_r;
  logic        zero_r;

  logic [4:0]  nib_s;
  logic [15:0] partial_next_s;

  function automatic logic [4:0] add_nibble(input logic [3:0] x, input logic [3:0] y,
                                            input logic cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

  // One nibble of the sum for the current index, merged into the partial result
  always_comb begin
    nib_s          = add_nibble(op_a_r[{idx_r, 2'b00} +: 4], op_b_r[{idx_r, 2'b00} +: 4], carry_r);
    partial_next_s = partial_r;
    partial_next_s[{idx_r, 2'b00} +: 4] = nib_s[3:0];
  end

  // Control FSM and datapath registers; results update only on the last nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_a_r    <= 16'h0000;
      op_b_r    <= 16'h0000;
      partial_r <= 16'h0000;
      carry_r   <= 1'b0;
      idx_r     <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sum_r     <= 16'h0000;
      c_out_r   <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_a_r    <= bus.a;
            op_b_r    <= bus.op_sub ? ~bus.b : bus.b;
            carry_r   <= bus.op_sub;
            idx_r     <= 2'd0;
            partial_r <= 16'h0000;
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            state_r   <= IDLE;
          end
        end
        RUN: begin
          partial_r <= partial_next_s;
          carry_r   <= nib_s[4];
          if (idx_r == 2'd3) begin
            // Operand sign bits already reflect the inversion applied for subtraction
            sum_r   <= partial_next_s;
            c_out_r <= nib_s[4];
            ovf_r   <= (op_a_r[15] == op_b_r[15]) && (partial_next_s[15] != op_a_r[15]);
            zero_r  <= (partial_next_s == 16'h0000);
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + 2'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.zero  = zero_r;

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Randomized and directed checks of nibble_serial_add16 against an arithmetic reference model.
module tb_nibble_serial_add16;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  res_t hold;

  nibble_serial_add16_if bus();

  nibble_serial_add16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    res_t        r;
    int          sa;
    int          sb;
    int          full;
    logic [16:0] u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u    = {1'b0, a} - {1'b0, b};
      r.c  = (a >= b);
      full = sa - sb;
    end else begin
      u    = {1'b0, a} + {1'b0, b};
      r.c  = u[16];
      full = sa + sb;
    end
    r.s = u[15:0];
    r.v = (full > 32767) || (full < -32768);
    r.z = (r.s == 16'h0000);
    return r;
  endfunction

  // Present operands for one edge, then scramble them so in-flight state must come from the latch
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic sub);
    bus.start  = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = sub;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.a      = 16'($urandom);
    bus.b      = 16'($urandom);
    bus.op_sub = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h4321; bus.op_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.zero} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got %h required 0", {bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.zero});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_after_reset busy=%b done=%b required busy=1 done=0", bus.busy, bus.done);
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 16'h5555) begin
      errors++;
      $display("FAIL reset_first_op done=%b sum=%h required done=1 sum=5555", bus.done, bus.sum);
    end
    hold = ref_op(16'h1234, 16'h4321, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    res_t        te [5] = '{{16'h5555, 1'b0, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0, 1'b1},
                            {16'h8000, 1'b0, 1'b1, 1'b0}, {16'hFFFE, 1'b0, 1'b0, 1'b0},
                            {16'h7FFF, 1'b1, 1'b1, 1'b0}};
    for (int k = 0; k < 5; k++) begin
      launch(ta[k], tb[k], ts[k]);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== hold) begin
          errors++;
          $display("FAIL directed_run k=%0d c=%0d busy=%b done=%b res=%h required busy=1 done=0 res=%h",
                   k, c, bus.busy, bus.done, {bus.sum, bus.c_out, bus.ovf, bus.zero}, hold);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== te[k]) begin
        errors++;
        $display("FAIL directed_done k=%0d done=%b busy=%b sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                 k, bus.done, bus.busy, bus.sum, bus.c_out, bus.ovf, bus.zero, te[k].s, te[k].c, te[k].v, te[k].z);
      end
      hold = te[k];
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== hold) begin
        errors++;
        $display("FAIL directed_idle k=%0d done=%b busy=%b sum=%h required done=0 busy=0 sum=%h",
                 k, bus.done, bus.busy, bus.sum, hold.s);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    res_t        exp;
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (k < 3) rb = ra;
      exp = ref_op(ra, rb, rs);
      launch(ra, rb, rs);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== hold) begin
          errors++;
          $display("FAIL random_run k=%0d c=%0d busy=%b done=%b res=%h required busy=1 done=0 res=%h",
                   k, c, bus.busy, bus.done, {bus.sum, bus.c_out, bus.ovf, bus.zero}, hold);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== exp) begin
        errors++;
        $display("FAIL random_done a=%h b=%h sub=%b got sum=%h c=%b v=%b z=%b done=%b required sum=%h c=%b v=%b z=%b",
                 ra, rb, rs, bus.sum, bus.c_out, bus.ovf, bus.zero, bus.done, exp.s, exp.c, exp.v, exp.z);
      end
      hold = exp;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t exp;
    bus.start = 1'b1;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op_sub = 1'($urandom);
    q.push_back(ref_op(bus.a, bus.b, bus.op_sub));
    for (int n = 0; n < 24; n++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (n % 6 == 4) begin
        exp = (q.size() > 0) ? q.pop_front() : hold;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== exp) begin
          errors++;
          $display("FAIL b2b_done n=%0d done=%b busy=%b res=%h required done=1 busy=0 res=%h",
                   n, bus.done, bus.busy, {bus.sum, bus.c_out, bus.ovf, bus.zero}, exp);
        end
        hold = exp;
      end else if (bus.busy !== (n % 6 <= 3) || bus.done !== 1'b0 ||
                   {bus.sum, bus.c_out, bus.ovf, bus.zero} !== hold) begin
        errors++;
        $display("FAIL b2b_state n=%0d busy=%b done=%b res=%h required busy=%b done=0 res=%h",
                 n, bus.busy, bus.done, {bus.sum, bus.c_out, bus.ovf, bus.zero}, (n % 6 <= 3), hold);
      end
      if (n < 23) begin
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.op_sub = 1'($urandom);
        if ((n + 1) % 6 == 0) q.push_back(ref_op(bus.a, bus.b, bus.op_sub));
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    res_t        exp;
    launch(16'h1234, 16'h4321, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.sum !== 16'h5555) begin
      errors++;
      $display("FAIL abort_first done=%b sum=%h required done=1 sum=5555", bus.done, bus.sum);
    end
    @(negedge clk);
    launch(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.zero} !== 21'd0) begin
      errors++;
      $display("FAIL abort_reset got %h required 0", {bus.busy, bus.done, bus.sum, bus.c_out, bus.ovf, bus.zero});
    end
    rst  = 1'b0;
    hold = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== hold) begin
        errors++;
        $display("FAIL abort_quiet c=%0d done=%b busy=%b sum=%h required done=0 busy=0 sum=0",
                 c, bus.done, bus.busy, bus.sum);
      end
    end
    ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
    exp = ref_op(ra, rb, rs);
    launch(ra, rb, rs);
    repeat (4) @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || {bus.sum, bus.c_out, bus.ovf, bus.zero} !== exp) begin
      errors++;
      $display("FAIL abort_next done=%b res=%h required done=1 res=%h",
               bus.done, {bus.sum, bus.c_out, bus.ovf, bus.zero}, exp);
    end
    hold = exp;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hold   = '0;
    rst    = 1'b1;
    bus.start = 1'b0; bus.a = 16'h0000; bus.b = 16'h0000; bus.op_sub = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
Parameters: none.
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 a  input  16  first operand; sampled with start.
REQ-007 b  input  16  second operand; sampled with start.
REQ-008 busy  output  1  high while nibble iterations are in progress (RUN).
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 sum  output  16  registered result.
REQ-011 c_out  output  1  carry out of bit 15. For subtraction, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow.
REQ-013 zero  output  1  high when sum == 16'h0000.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, one-hot or binary, with no other reachable states.
REQ-015 IDLE with start=1: latch a into op_a, and b (op_sub=0) or ~b (op_sub=1) into op_b; carry register = op_sub; nibble index = 0; next state RUN.
REQ-016 IDLE with start=0: remain in IDLE and hold all outputs.
REQ-017 Each RUN cycle SHALL add op_a[4i+3:4i] + op_b[4i+3:4i] + carry with a 4-bit full-adder datapath, where i is the nibble index.
  - Write the 4-bit result into partial[4i+3:4i].
  - Update the carry register with the nibble carry out.
  - Increment i.
REQ-018 The RUN to DONE transition SHALL occur after nibble 3 is processed. The RUN state lasts exactly 4 cycles; the index SHALL NOT wrap into a fifth iteration.
REQ-019 On entry to DONE, the block SHALL register the following:
  - sum = partial.
  - c_out = final carry.
  - ovf = (op_a[15] == op_b[15]) && (partial[15] != op_a[15]).
  - zero = (partial == 0).
REQ-020 DONE SHALL last one cycle, with done=1 and busy=0, then return to IDLE unconditionally.
REQ-021 Latency: if start is accepted at the edge ending cycle T, busy=1 in cycles T+1..T+4 and done=1 in cycle T+5. Minimum start-to-start spacing is 6 cycles.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing.
REQ-023 Changes to a, b and op_sub after acceptance SHALL NOT affect the operation in flight.
REQ-024 sum, c_out, ovf and zero SHALL hold their values from DONE until the next DONE entry; they do not change during a subsequent RUN.
REQ-025 busy and done SHALL never be high in the same cycle.

Reset
REQ-026 When rst=1 at a rising edge, the following SHALL apply regardless of state:
  - state = IDLE.
  - busy = 0, done = 0.
  - sum = 16'h0000, c_out = 0, ovf = 0, zero = 0.
  - Internal operand, partial, carry and index registers cleared.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse. Outputs SHALL NOT reflect the aborted operation.
REQ-028 rst SHALL take priority over start in the same cycle.
REQ-029 start SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-030 add 16'h1234 + 16'h4321 -> sum=16'h5555, c_out=0, ovf=0, zero=0; busy high for 4 cycles; done pulses in cycle T+5.
REQ-031 add 16'hFFFF + 16'h0001 -> sum=16'h0000, c_out=1, ovf=0, zero=1. This checks carry ripple across all four nibbles.
REQ-032 add 16'h7FFF + 16'h0001 -> sum=16'h8000, c_out=0, ovf=1, zero=0.
REQ-033 sub 16'h0005 - 16'h0007 -> sum=16'hFFFE, c_out=0, ovf=0. Then sub 16'h8000 - 16'h0001 -> sum=16'h7FFF, c_out=1, ovf=1.
REQ-034 Hold start=1 continuously and change a and b every cycle -> operations are accepted only every 6 cycles. Each result matches the operands sampled at acceptance.
REQ-035 Abort case: complete one add (sum=16'h5555), start another, and assert rst in cycle T+2 -> the following cycle shows busy=0, done=0, sum=16'h0000. No done pulse follows, and the next start completes normally.
